// File: rtl/color_scan_sched.sv
// color_scan_sched: round-robin scheduler sharing one RGB frequency counter
// between the object and station color sensors.
module color_scan_sched #(
   parameter int PERIOD = 2000,
   parameter int SETTLE = 200,
   parameter int CNT_W  = 10
) (
   input  logic             clkus,
   input  logic             rst,
   input  logic             req_obj,
   input  logic             req_stn,
   input  logic             obj_wave,
   input  logic             stn_wave,
   output logic [1:0]       obj_select,
   output logic [1:0]       stn_select,
   output logic             obj_led,
   output logic             stn_led,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [CNT_W-1:0] cnt_r,
   output logic [CNT_W-1:0] cnt_g,
   output logic [CNT_W-1:0] cnt_b
);
   localparam int LEN = (PERIOD > SETTLE) ? PERIOD : SETTLE;
   localparam int TW  = $clog2(LEN + 1);
   localparam logic [TW-1:0] PER_END = TW'(PERIOD - 1);
   localparam logic [TW-1:0] SET_END = TW'(SETTLE - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_CNT_R, ST_CNT_G, ST_CNT_B, ST_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [TW-1:0]    r_tmr;
   logic             r_gnt, r_last, r_done_id;
   logic [2:0]       r_obj_sh, r_stn_sh;
   logic [CNT_W-1:0] r_acc [3];
   logic [CNT_W-1:0] w_acc_nxt [3];
   logic [CNT_W-1:0] r_cnt_r, r_cnt_g, r_cnt_b;
   logic             w_tmr_end, w_pick, w_edge, w_cnt, w_led;
   logic [1:0]       w_col, w_sel;

   // shift chain: [0],[1] synchronize, [2] holds the previous synchronized level
   assign w_edge    = r_gnt ? (r_stn_sh[1] & ~r_stn_sh[2]) : (r_obj_sh[1] & ~r_obj_sh[2]);
   assign w_pick    = (req_obj & req_stn) ? ~r_last : req_stn;
   assign w_tmr_end = r_tmr == ((r_state == ST_SETTLE) ? SET_END : PER_END);

   always_ff @(posedge clkus or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= (w_state_nxt != r_state || r_state == ST_IDLE) ? '0 : r_tmr + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   w_state_nxt = (req_obj | req_stn) ? ST_SETTLE : ST_IDLE;
         ST_SETTLE: w_state_nxt = w_tmr_end ? ST_CNT_R : ST_SETTLE;
         ST_CNT_R:  w_state_nxt = w_tmr_end ? ST_CNT_G : ST_CNT_R;
         ST_CNT_G:  w_state_nxt = w_tmr_end ? ST_CNT_B : ST_CNT_G;
         ST_CNT_B:  w_state_nxt = w_tmr_end ? ST_DONE : ST_CNT_B;
         default:   w_state_nxt = ST_IDLE;
      endcase
      w_cnt = r_state inside {ST_CNT_R, ST_CNT_G, ST_CNT_B};
      w_led = w_cnt | (r_state == ST_SETTLE);
      w_col = (r_state == ST_CNT_G) ? 2'd1 : (r_state == ST_CNT_B) ? 2'd2 : 2'd0;
      w_sel = !w_led ? 2'b11 : (r_state == ST_CNT_G) ? 2'b11 : (r_state == ST_CNT_B) ? 2'b01 : 2'b00;
      for (int c = 0; c < 3; c++)
         w_acc_nxt[c] = (r_state == ST_SETTLE) ? '0 :
                        (w_cnt && w_col == 2'(c) && w_edge && r_acc[c] != '1) ? r_acc[c] + 1'b1 : r_acc[c];
   end

   always_ff @(posedge clkus or posedge rst) begin
      if (rst) begin
         r_gnt     <= 1'b0;
         r_last    <= 1'b1;
         r_done_id <= 1'b0;
         r_obj_sh  <= '0;
         r_stn_sh  <= '0;
         r_acc     <= '{default: '0};
         r_cnt_r   <= '0;
         r_cnt_g   <= '0;
         r_cnt_b   <= '0;
      end else begin
         r_obj_sh <= {r_obj_sh[1:0], obj_wave};
         r_stn_sh <= {r_stn_sh[1:0], stn_wave};
         r_acc    <= w_acc_nxt;
         if (r_state == ST_IDLE && w_state_nxt == ST_SETTLE)
            r_gnt <= w_pick;
         // results latch on DONE entry so the final CNT_B edge is included
         if (r_state == ST_CNT_B && w_state_nxt == ST_DONE) begin
            r_cnt_r   <= w_acc_nxt[0];
            r_cnt_g   <= w_acc_nxt[1];
            r_cnt_b   <= w_acc_nxt[2];
            r_done_id <= r_gnt;
            r_last    <= r_gnt;
         end
      end
   end

   assign obj_select = r_gnt ? 2'b11 : w_sel;
   assign stn_select = r_gnt ? w_sel : 2'b11;
   assign obj_led    = w_led & ~r_gnt;
   assign stn_led    = w_led & r_gnt;
   assign busy       = r_state != ST_IDLE;
   assign done       = r_state == ST_DONE;
   assign done_id    = r_done_id;
   assign cnt_r      = r_cnt_r;
   assign cnt_g      = r_cnt_g;
   assign cnt_b      = r_cnt_b;
endmodule

// File: tb/tb_color_scan_sched.sv
// tb_color_scan_sched: two scheduler configurations driven in lockstep and
// compared every cycle against a scan-timeline reference model.
module tb_color_scan_sched;
   localparam int P0 = 20, S0 = 4, W0 = 10;
   localparam int P1 = 40, S1 = 4, W1 = 4;
   localparam logic [38:0] RST_V = {3'b000, 2'b11, 2'b11, 2'b00, 30'd0};

   logic clkus = 0, rst = 1, req_obj = 0, req_stn = 0, obj_wave = 0, stn_wave = 0;
   logic [1:0] obj_sel [2], stn_sel [2];
   logic obj_led [2], stn_led [2], busy [2], done [2], done_id [2];
   logic [W0-1:0] cr0, cg0, cb0;
   logic [W1-1:0] cr1, cg1, cb1;

   always #5 clkus = ~clkus;

   color_scan_sched #(.PERIOD(P0), .SETTLE(S0), .CNT_W(W0)) dut0 (
      .clkus(clkus), .rst(rst), .req_obj(req_obj), .req_stn(req_stn),
      .obj_wave(obj_wave), .stn_wave(stn_wave),
      .obj_select(obj_sel[0]), .stn_select(stn_sel[0]), .obj_led(obj_led[0]), .stn_led(stn_led[0]),
      .busy(busy[0]), .done(done[0]), .done_id(done_id[0]), .cnt_r(cr0), .cnt_g(cg0), .cnt_b(cb0));

   color_scan_sched #(.PERIOD(P1), .SETTLE(S1), .CNT_W(W1)) dut1 (
      .clkus(clkus), .rst(rst), .req_obj(req_obj), .req_stn(req_stn),
      .obj_wave(obj_wave), .stn_wave(stn_wave),
      .obj_select(obj_sel[1]), .stn_select(stn_sel[1]), .obj_led(obj_led[1]), .stn_led(stn_led[1]),
      .busy(busy[1]), .done(done[1]), .done_id(done_id[1]), .cnt_r(cr1), .cnt_g(cg1), .cnt_b(cb1));

   // model: per instance, a scan is "grant cycle ms" plus offsets along its timeline
   int pp [2] = '{P0, P1};
   int sp [2] = '{S0, S1};
   int mx [2] = '{(1 << W0) - 1, (1 << W1) - 1};
   bit mb [2], mg [2], ml [2], eid [2];
   int ms [2];
   int acc [2][3];
   int ec [2][3];
   bit po1, po2, ps1, ps2;
   int k = 0, tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [38:0] obs, input logic [38:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [38:0] obs_v(input int i);
      if (i == 0)
         return {busy[0], done[0], done_id[0], obj_sel[0], stn_sel[0], obj_led[0], stn_led[0], cr0, cg0, cb0};
      return {busy[1], done[1], done_id[1], obj_sel[1], stn_sel[1], obj_led[1], stn_led[1],
              6'd0, cr1, 6'd0, cg1, 6'd0, cb1};
   endfunction

   function automatic logic [38:0] exp_v(input int i);
      int  o = k - ms[i];
      int  last = sp[i] + 3 * pp[i];
      bit  led = mb[i] && o < last;
      logic [1:0] sel = !led ? 2'b11 : o < sp[i] + pp[i] ? 2'b00 : o < sp[i] + 2 * pp[i] ? 2'b11 : 2'b01;
      return {mb[i], mb[i] && o == last, eid[i], mg[i] ? 2'b11 : sel, mg[i] ? sel : 2'b11,
              led && !mg[i], led && mg[i], 10'(ec[i][0]), 10'(ec[i][1]), 10'(ec[i][2])};
   endfunction

   task automatic step();
      bit ro, rs, rg;
      int o, last;
      @(posedge clkus);
      k++;
      ro = po1 & ~po2;
      rs = ps1 & ~ps2;
      po2 = po1; ps2 = ps1;
      po1 = rst ? 1'b0 : obj_wave;
      ps1 = rst ? 1'b0 : stn_wave;
      for (int i = 0; i < 2; i++) begin
         o = k - ms[i];
         last = sp[i] + 3 * pp[i];
         rg = mg[i] ? rs : ro;
         if (rst) begin
            mb[i] = 0; ml[i] = 1; eid[i] = 0; mg[i] = 0;
            for (int c = 0; c < 3; c++) ec[i][c] = 0;
         end else if (mb[i]) begin
            if (rg && o >= sp[i] && o < last && acc[i][(o - sp[i]) / pp[i]] < mx[i])
               acc[i][(o - sp[i]) / pp[i]]++;
            if (o == last) begin
               ec[i] = acc[i]; eid[i] = mg[i]; ml[i] = mg[i];
            end
            if (o == last + 1) mb[i] = 0;
         end else if (req_obj || req_stn) begin
            mg[i] = (req_obj && req_stn) ? !ml[i] : req_stn;
            mb[i] = 1; ms[i] = k;
            for (int c = 0; c < 3; c++) acc[i][c] = 0;
         end
      end
      #1;
      for (int i = 0; i < 2; i++) chk($sformatf("cyc%0d_u%0d", k, i), obs_v(i), exp_v(i));
   endtask

   task automatic do_reset();
      rst = 1; req_obj = 0; req_stn = 0;
      repeat (2) step();
      rst = 0;
   endtask

   initial begin
      int n, first;
      logic [3:0] ids;
      do_reset();
      chk("reset_state", obs_v(0), RST_V);
      // object scan with 5/3/7 edges, including last-cycle edges of R and B
      for (int j = 0; j < 130; j++) begin
         req_obj = (j == 0);
         obj_wave = (j <= 64) ? (j inside {4, 7, 10, 13, 22, 25, 29, 33, 44, 46, 49, 52, 55, 58, 62}) : 1'($urandom);
         stn_wave = 1'($urandom);
         step();
         if (j == 64) chk("scan_5_3_7", {done[0], done_id[0], cr0, cg0, cb0}, {1'b1, 1'b0, 10'd5, 10'd3, 10'd7});
      end
      // both requesters held: strict alternation
      do_reset();
      req_obj = 1; req_stn = 1; n = 0; ids = '0;
      for (int j = 0; j < 270; j++) begin
         obj_wave = 1'($urandom); stn_wave = 1'($urandom);
         step();
         if (done[0]) begin
            if (n < 4) ids[3 - n] = done_id[0];
            n++;
         end
      end
      chk("alt_count", 39'(n), 39'd4);
      chk("alt_ids", 39'(ids), 39'b0101);
      // saturation on the 4-bit instance
      do_reset();
      for (int j = 0; j < 130; j++) begin
         req_obj = (j == 0); obj_wave = j[0]; stn_wave = 1'($urandom);
         step();
         if (j == 124) chk("saturate", {done[1], cr1, cg1, cb1}, {1'b1, 4'd15, 4'd15, 4'd15});
      end
      // reset in the middle of CNT_G, then a station-only request
      do_reset();
      for (int j = 0; j < 30; j++) begin
         req_obj = (j == 0); obj_wave = 1'($urandom); stn_wave = 1'($urandom);
         step();
      end
      rst = 1;
      #1;
      chk("rst_async", obs_v(0), RST_V);
      repeat (3) step();
      rst = 0; req_stn = 1; n = 0; first = 2;
      for (int j = 0; j < 140; j++) begin
         obj_wave = 1'($urandom); stn_wave = 1'($urandom);
         step();
         if (done[0]) begin
            if (n == 0) first = done_id[0];
            n++;
         end
      end
      chk("post_rst_id", 39'(first), 39'd1);
      chk("post_rst_n", 39'(n), 39'd2);
      // request dropped during CNT_R
      do_reset();
      n = 0;
      for (int j = 0; j < 140; j++) begin
         req_obj = (j < 15); obj_wave = 1'($urandom); stn_wave = 1'($urandom);
         step();
         if (done[0]) n++;
      end
      chk("drop_n", 39'(n), 39'd1);
      chk("drop_busy", 39'(busy[0]), 39'd0);
      // random request levels and waves
      do_reset();
      for (int j = 0; j < 800; j++) begin
         if ($urandom_range(0, 31) == 0) req_obj = ~req_obj;
         if ($urandom_range(0, 31) == 0) req_stn = ~req_stn;
         obj_wave = 1'($urandom); stn_wave = 1'($urandom);
         step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/color_scan_sched.md
Name: color_scan_sched

Overview:
- Scheduler that shares one frequency-counting datapath between the object and station color sensors.
- Each sensor requests a scan. The block grants one requester at a time, round-robin, and drives that sensor's filter select and LED.
- It counts the sensor's square-wave rising edges in R, G and B windows, then returns the three counts with a one-cycle done pulse and the id of the served sensor.
- Sits between the sensor pins and the color classification logic in Core.

Parameters:
PERIOD, 2000, counting window per color in clkus cycles (2 ms at 1 MHz)
SETTLE, 200, cycles after grant before the R window opens (LED/filter settling)
CNT_W, 10, width of each color count

Ports:
clkus  input  1  1 MHz system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
req_obj  input  1  object sensor scan request (level)
req_stn  input  1  station sensor scan request (level)
obj_wave  input  1  object sensor square wave, asynchronous
stn_wave  input  1  station sensor square wave, asynchronous
obj_select  output  2  object sensor {S2,S3}
stn_select  output  2  station sensor {S2,S3}
obj_led  output  1  object sensor LED enable
stn_led  output  1  station sensor LED enable
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: counts valid
done_id  output  1  0 = object, 1 = station; valid with done, held after
cnt_r, cnt_g, cnt_b  output  CNT_W each  result counts, held until next done

Behaviour:
- Reset values:
  - state IDLE, obj_select = stn_select = 2'b11, leds 0, busy 0, done 0, done_id 0, cnt_* 0.
  - last_served = 1 (station), so the object sensor wins the first tie.
  - Reset asserted mid-scan aborts immediately. No done is produced for the aborted scan.
- Select codes: R = 2'b00, G = 2'b11, B = 2'b01. A sensor that is not granted, or any sensor while in IDLE, gets 2'b11 with LED 0.
- Wave input handling:
  - Each wave passes through a 2-flop synchronizer, then a rising-edge detector (sync high, previous sync low).
  - Only the granted sensor's detected edges are counted. The other wave is ignored.
- FSM: IDLE -> SETTLE -> CNT_R -> CNT_G -> CNT_B -> DONE -> IDLE.
- IDLE arbitration:
  - Requests are sampled each cycle.
  - One request: that sensor is granted.
  - Both requests: the sensor not equal to last_served is granted.
  - The grant registers gnt and moves to SETTLE on the next edge.
- SETTLE:
  - Granted LED = 1, select = R code. Lasts exactly SETTLE cycles.
  - The internal accumulator clears to 0 on SETTLE entry.
- CNT_R / CNT_G / CNT_B:
  - Each state lasts exactly PERIOD cycles. Select = the corresponding code, applied on the first cycle of the state. LED stays 1.
  - An edge detected in a cycle is counted into the color of the state current in that cycle, including the last cycle of a window.
  - Each accumulator saturates at 2^CNT_W-1; it does not wrap.
- DONE (one cycle):
  - cnt_r/g/b register the accumulators. done = 1, done_id = gnt, last_served = gnt.
  - LED goes 0 and select goes 2'b11 in this cycle.
  - The next cycle is IDLE, and arbitration may grant again there.
- busy is 1 in SETTLE through DONE inclusive.
- Latency: a request seen in IDLE at cycle t gives done at cycle t+1+SETTLE+3*PERIOD.
- Requests are not acknowledged individually; done with a matching done_id is the ack.
  - Deasserting req mid-scan does not abort the scan.
  - A request held through done is serviced again; round-robin guarantees the other pending requester is served first.
- cnt_* and done_id are stable outside the done cycle.

Test Plan:
1. PERIOD=20, SETTLE=4, only req_obj held 1 cycle; obj_wave edges 5/3/7 in the R/G/B windows -> done at t+65, done_id=0, cnt_r=5, cnt_g=3, cnt_b=7, obj_select sequence 00,11,01 then 11; stn_led stays 0.
2. req_obj and req_stn both held continuously from reset -> done_ids alternate 0,1,0,1. Between each done and the next grant there is exactly one IDLE cycle.
3. obj_wave at 1 edge per 2 cycles with CNT_W=4 -> cnt_r=cnt_g=cnt_b=15 (saturated, no wrap).
4. Edge synchronized onto the last cycle of CNT_R -> counted in cnt_r, not cnt_g. stn_wave toggling during an object scan -> object counts unaffected.
5. rst asserted mid-CNT_G for 3 cycles -> all outputs return to reset values immediately, no done for the aborted scan. After release with req_stn held, the station is granted and a normal scan completes.
6. req_obj dropped during CNT_R -> scan continues to completion; done pulses once and busy returns to 0 afterwards.
